pc_sequencer: RTL and testbench

- SEQ-stage controller that owns the architectural program counter and the processor status register.
- Drives PC into the fetch stage and selects the next PC from fetch/execute/memory results (valP, valC, valM, cnd).
- Runs the RUN/HALT/FAULT state machine that stops the machine on halt, bad instruction or memory error.
- Generates the commit strobe that gates register-file and data-memory writes, and keeps cycle and retired-instruction counters.

---
 rtl/y86_pkg.sv | 34 +++
 rtl/next_pc_sel.sv | 22 ++
 rtl/pc_sequencer.sv | 121 ++++++++++++
 tb/tb_pc_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 constants: instruction codes, status codes and sequencer state encoding.
// The BREAK state exists only when PC_BREAKPOINT_EN is defined.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [2:0] {
    StatAok = 3'd1,
    StatHlt = 3'd2,
    StatAdr = 3'd3,
    StatIns = 3'd4
  } stat_e;

  typedef enum logic [1:0] {
    StRun,
    StHalt,
    StFault
`ifdef PC_BREAKPOINT_EN
    , StBreak
`endif
  } seq_state_e;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC mux: call/taken jump -> valC, ret -> valM, else valP.
module next_pc_sel
  import y86_pkg::*;
(
  input  logic [3:0]  icode,
  input  logic        cnd,
  input  logic [63:0] valC,
  input  logic [63:0] valP,
  input  logic [63:0] valM,
  output logic [63:0] new_pc
);

  always_comb begin
    new_pc = valP;
    if (icode == I_CALL || (icode == I_JXX && cnd)) begin
      new_pc = valC;
    end else if (icode == I_RET) begin
      new_pc = valM;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// SEQ-stage PC/status owner with RUN/HALT/FAULT state machine, commit strobe and
// saturating cycle/retire counters. Define PC_BREAKPOINT_EN to add a BREAK state.
module pc_sequencer
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             cnd,
  input  logic [63:0]      valC,
  input  logic [63:0]      valP,
  input  logic [63:0]      valM,
  input  logic             dmem_error,
  input  logic             stall_in,
  output logic [63:0]      PC,
  output logic [2:0]       stat,
  output logic             commit,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
`ifdef PC_BREAKPOINT_EN
  ,
  input  logic             bp_en,
  input  logic [63:0]      bp_addr,
  input  logic             resume,
  output logic             at_break
`endif
);

  seq_state_e       r_state;
  stat_e            r_stat;
  logic [63:0]      r_pc;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instr_cnt;
  logic [63:0]      w_next_pc;
  logic             w_bp_hit;

  next_pc_sel u_next_pc_sel (
    .icode  (icode),
    .cnd    (cnd),
    .valC   (valC),
    .valP   (valP),
    .valM   (valM),
    .new_pc (w_next_pc)
  );

`ifdef PC_BREAKPOINT_EN
  logic r_skip;
  assign w_bp_hit = bp_en && (r_pc == bp_addr) && !r_skip;
  assign at_break = (r_state == StBreak);
`else
  assign w_bp_hit = 1'b0;
`endif

  // Reset forces commit low immediately, before any clock edge.
  assign commit = !rst && (r_state == StRun) && !stall_in && !w_bp_hit && !imem_error &&
                  !dmem_error && instr_valid && (icode != I_HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StRun;
      r_stat      <= StatAok;
      r_pc        <= RESET_PC;
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
`ifdef PC_BREAKPOINT_EN
      r_skip      <= 1'b0;
`endif
    end else begin
      case (r_state)
        StRun: begin
          if (!(&r_cycle_cnt)) r_cycle_cnt <= r_cycle_cnt + 1'b1;
          if (stall_in) begin
            r_state <= StRun;
`ifdef PC_BREAKPOINT_EN
          end else if (w_bp_hit) begin
            r_state <= StBreak;
`endif
          end else if (imem_error || dmem_error) begin
            r_state <= StFault;
            r_stat  <= StatAdr;
          end else if (!instr_valid) begin
            r_state <= StFault;
            r_stat  <= StatIns;
          end else begin
            // Halt retires but leaves PC at the halt address.
            if (icode == I_HALT) begin
              r_state <= StHalt;
              r_stat  <= StatHlt;
            end else begin
              r_pc <= w_next_pc;
            end
            if (!(&r_instr_cnt)) r_instr_cnt <= r_instr_cnt + 1'b1;
`ifdef PC_BREAKPOINT_EN
            r_skip <= 1'b0;
`endif
          end
        end
`ifdef PC_BREAKPOINT_EN
        StBreak: begin
          if (resume) begin
            r_state <= StRun;
            r_skip  <= 1'b1;
          end
        end
`endif
        default: r_state <= r_state;
      endcase
    end
  end

  assign PC        = r_pc;
  assign stat      = r_stat;
  assign cycle_cnt = r_cycle_cnt;
  assign instr_cnt = r_instr_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: driver pushes model expectations, monitor pops and compares.
module tb_pc_sequencer;

  localparam int unsigned CW      = 6;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    icode = 4'h1;
  logic          instr_valid = 1'b1;
  logic          imem_error = 1'b0;
  logic          cnd = 1'b0;
  logic [63:0]   valC = '0;
  logic [63:0]   valP = '0;
  logic [63:0]   valM = '0;
  logic          dmem_error = 1'b0;
  logic          stall_in = 1'b0;
  logic [63:0]   PC;
  logic [2:0]    stat;
  logic          commit;
  logic [CW-1:0] cycle_cnt;
  logic [CW-1:0] instr_cnt;

  pc_sequencer #(.RESET_PC(64'h0), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .icode       (icode),
    .instr_valid (instr_valid),
    .imem_error  (imem_error),
    .cnd         (cnd),
    .valC        (valC),
    .valP        (valP),
    .valM        (valM),
    .dmem_error  (dmem_error),
    .stall_in    (stall_in),
    .PC          (PC),
    .stat        (stat),
    .commit      (commit),
    .cycle_cnt   (cycle_cnt),
    .instr_cnt   (instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        commit;
    logic [63:0] pc;
    logic [2:0]  stat;
    int          cyc;
    int          ins;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: architectural state only.
  logic [63:0] m_pc;
  int          m_stat, m_cyc, m_ins;
  bit          m_done;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic int sat(int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // Drive one instruction at a negedge, push the expected result, advance to the next negedge.
  task automatic apply(string name, logic [3:0] ic, bit vld, bit ierr, bit derr, bit c,
                       logic [63:0] vc, logic [63:0] vp, logic [63:0] vm, bit stl);
    exp_t e;
    icode = ic; instr_valid = vld; imem_error = ierr; dmem_error = derr; cnd = c;
    valC = vc; valP = vp; valM = vm; stall_in = stl;
    e.name   = name;
    e.commit = 1'b0;
    if (!m_done) begin
      m_cyc = sat(m_cyc);
      e.commit = !stl && !ierr && !derr && vld && (ic != 4'h0);
      if (stl) begin
      end else if (ierr || derr) begin
        m_stat = 3; m_done = 1;
      end else if (!vld) begin
        m_stat = 4; m_done = 1;
      end else if (ic == 4'h0) begin
        m_stat = 2; m_done = 1; m_ins = sat(m_ins);
      end else begin
        if (ic == 4'h8 || (ic == 4'h7 && c)) m_pc = vc;
        else if (ic == 4'h9) m_pc = vm;
        else m_pc = vp;
        m_ins = sat(m_ins);
      end
    end
    e.pc = m_pc; e.stat = 3'(m_stat); e.cyc = m_cyc; e.ins = m_ins;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic nop(string name);
    apply(name, 4'h1, 1, 0, 0, 0, 64'h0, m_pc + 64'd1, 64'h0, 0);
  endtask

  // Asynchronous reset mid-cycle, checked immediately, released at the next negedge.
  task automatic do_reset(string name);
    #2 rst = 1'b1;
    #1;
    check({name, "_pc"}, PC, 64'h0);
    check({name, "_stat"}, 64'(stat), 64'd1);
    check({name, "_cyc"}, 64'(cycle_cnt), 64'd0);
    check({name, "_ins"}, 64'(instr_cnt), 64'd0);
    check({name, "_commit"}, 64'(commit), 64'd0);
    m_pc = '0; m_stat = 1; m_cyc = 0; m_ins = 0; m_done = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rand_instr();
    logic [3:0] ic;
    ic = ($urandom_range(0, 19) == 0) ? 4'h0 : 4'($urandom_range(1, 11));
    apply("rand", ic, $urandom_range(0, 49) != 0, $urandom_range(0, 49) == 0,
          $urandom_range(0, 49) == 0, 1'($urandom), {$urandom, $urandom},
          m_pc + 64'($urandom_range(1, 10)), {$urandom, $urandom}, $urandom_range(0, 4) == 0);
  endtask

  // Monitor: commit sampled mid-low-phase, state sampled just after the rising edge.
  initial begin
    logic  c_smp;
    exp_t  e;
    forever begin
      @(negedge clk);
      #3 c_smp = commit;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.name, "_commit"}, 64'(c_smp), 64'(e.commit));
        check({e.name, "_pc"}, PC, e.pc);
        check({e.name, "_stat"}, 64'(stat), 64'(e.stat));
        check({e.name, "_cyc"}, 64'(cycle_cnt), 64'(e.cyc));
        check({e.name, "_ins"}, 64'(instr_cnt), 64'(e.ins));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    m_pc = '0; m_stat = 1; m_cyc = 0; m_ins = 0; m_done = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Sequential and control flow.
    for (int i = 0; i < 3; i++) nop("seq");
    apply("jxx_taken", 4'h7, 1, 0, 0, 1, 64'h40, 64'h44, 64'h0, 0);
    apply("jxx_not", 4'h7, 1, 0, 0, 0, 64'h80, 64'h49, 64'h0, 0);
    apply("call", 4'h8, 1, 0, 0, 0, 64'h100, 64'h49, 64'h0, 0);
    apply("ret", 4'h9, 1, 0, 0, 0, 64'h0, 64'h101, 64'h13, 0);
    do_reset("rst_mid");

    // Halt at 0x20 stays frozen.
    apply("call20", 4'h8, 1, 0, 0, 0, 64'h20, 64'h9, 64'h0, 0);
    apply("halt", 4'h0, 1, 0, 0, 0, 64'h0, 64'h21, 64'h0, 0);
    for (int i = 0; i < 10; i++) rand_instr();
    do_reset("rst_halt");

    // Faults.
    apply("adr_over_ins", 4'h1, 0, 1, 0, 0, 64'h0, 64'h1, 64'h0, 0);
    apply("fault_hold", 4'h1, 1, 0, 0, 0, 64'h0, 64'h1, 64'h0, 0);
    do_reset("rst_f1");
    apply("ins", 4'h1, 0, 0, 0, 0, 64'h0, 64'h1, 64'h0, 0);
    do_reset("rst_f2");
    nop("pre_dmem");
    apply("dmem", 4'h5, 1, 0, 1, 0, 64'h0, 64'h77, 64'h0, 0);
    do_reset("rst_f3");

    // Stall masks errors.
    for (int i = 0; i < 3; i++) apply("stall", 4'h1, 1, 1, 0, 0, 64'h0, 64'h5, 64'h0, 1);
    nop("post_stall");
    do_reset("rst_stall");

    // Counter saturation.
    for (int i = 0; i < 70; i++) nop("sat");
    do_reset("rst_sat");

    // Random run with reset after the machine stops.
    for (int i = 0; i < 400; i++) begin
      if (m_done && $urandom_range(0, 3) == 0) do_reset("rst_rand");
      else rand_instr();
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
